// File: rtl/floo_eoc_collector_if.sv
// rtl/floo_eoc_collector_if.sv - control/status bundle between a bench and the EOC collector
interface floo_eoc_collector_if #(
  parameter int NumClusters = 32,
  parameter int CntWidth    = 32
);
  localparam int PopW = $clog2(NumClusters + 1);

  logic                   start_i;
  logic                   clear_i;
  logic [NumClusters-1:0] eoc_mask_i;
  logic [NumClusters-1:0] eoc_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   timeout_o;
  logic [NumClusters-1:0] eoc_seen_o;
  logic [PopW-1:0]        done_cnt_o;
  logic [CntWidth-1:0]    cycle_cnt_o;

  modport master (
    output start_i, clear_i, eoc_mask_i, eoc_i,
    input  busy_o, done_o, timeout_o, eoc_seen_o, done_cnt_o, cycle_cnt_o
  );

  modport slave (
    input  start_i, clear_i, eoc_mask_i, eoc_i,
    output busy_o, done_o, timeout_o, eoc_seen_o, done_cnt_o, cycle_cnt_o
  );
endinterface

// File: rtl/floo_eoc_collector.sv
// rtl/floo_eoc_collector.sv - sticky, maskable end-of-computation collector with drain window and watchdog
module floo_eoc_collector #(
  parameter int NumClusters   = 32,
  parameter int DrainCycles   = 100,
  parameter int TimeoutCycles = 0,
  parameter int CntWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  floo_eoc_collector_if.slave  bus
);
  localparam int PopW   = $clog2(NumClusters + 1);
  localparam int DrainW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
  localparam logic [DrainW-1:0]   DrainLast   = DrainW'((DrainCycles > 0) ? DrainCycles - 1 : 0);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT
  } state_e;

  state_e                 r_state, w_state_d;
  logic [NumClusters-1:0] r_seen, w_seen_d;
  logic [NumClusters-1:0] r_mask, w_mask_d;
  logic [CntWidth-1:0]    r_cycle_cnt, w_cycle_cnt_d;
  logic [DrainW-1:0]      r_drain_cnt, w_drain_cnt_d;
  logic                   w_complete;
  logic [CntWidth-1:0]    w_cycle_inc;
  logic [PopW-1:0]        w_popcnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_seen      <= '0;
      r_mask      <= '0;
      r_cycle_cnt <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_seen      <= w_seen_d;
      r_mask      <= w_mask_d;
      r_cycle_cnt <= w_cycle_cnt_d;
      r_drain_cnt <= w_drain_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_seen_d      = r_seen;
    w_mask_d      = r_mask;
    w_cycle_cnt_d = r_cycle_cnt;
    w_drain_cnt_d = r_drain_cnt;
    // Completion looks at the registered flags, so the last EOC costs one extra edge.
    w_complete    = &(r_seen | ~r_mask);
    w_cycle_inc   = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + 1'b1;

    if (bus.clear_i) begin
      w_state_d     = S_IDLE;
      w_seen_d      = '0;
      w_mask_d      = '0;
      w_cycle_cnt_d = '0;
      w_drain_cnt_d = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            w_state_d     = S_RUN;
            w_mask_d      = bus.eoc_mask_i;
            w_seen_d      = '0;
            w_cycle_cnt_d = '0;
            w_drain_cnt_d = '0;
          end
        end
        S_RUN: begin
          w_seen_d      = r_seen | (bus.eoc_i & r_mask);
          w_cycle_cnt_d = w_cycle_inc;
          if (w_complete) begin
            w_state_d     = (DrainCycles > 0) ? S_DRAIN : S_DONE;
            w_drain_cnt_d = '0;
          end else if ((TimeoutCycles > 0) && (r_cycle_cnt == TimeoutLast)) begin
            w_state_d = S_TIMEOUT;
          end
        end
        S_DRAIN: begin
          w_seen_d      = r_seen | (bus.eoc_i & r_mask);
          w_cycle_cnt_d = w_cycle_inc;
          if (r_drain_cnt == DrainLast) begin
            w_state_d = S_DONE;
          end else begin
            w_drain_cnt_d = r_drain_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < NumClusters; i++) begin
      w_popcnt = w_popcnt + PopW'(r_seen[i]);
    end
  end

  assign bus.busy_o      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done_o      = (r_state == S_DONE);
  assign bus.timeout_o   = (r_state == S_TIMEOUT);
  assign bus.eoc_seen_o  = r_seen;
  assign bus.done_cnt_o  = w_popcnt;
  assign bus.cycle_cnt_o = r_cycle_cnt;
endmodule
